pkt_comm_output_decoder: RTL
============================

// Module: pkt_comm_output_decoder
// PURPOSE
//  Receiving end of the application output stream (dout/wr_en/full) produced by pkt_comm-based
//  designs such as md5crypt. Parses 16-bit output words into pkt_comm v2 packets and verifies
//  both checksums. Presents header fields and payload words to a consumer with valid/ready.
//  Used in simulation benches and on-chip loopback self-test, between the app output and output_fifo.
// PARAMETERS
//  DISABLE_CHECKSUM  0      1: no checksum words expected/verified (matches app's own setting)
//  VERSION           2      required value of header byte 0
//  MAX_DATA_LEN      65536  data_len above this -> ERR_LEN
// PORTS
//  PKT_COMM_CLK  in   1   single clock, all logic rising-edge
//  rst_n         in   1   asynchronous, active-low reset
//  din           in   16  output word from application; low byte = earlier stream byte
//  wr_en         in   1   din valid this cycle
//  full          out  1   back-pressure to application; word not accepted while full=1
//  hdr_valid     out  1   one-cycle pulse: header fields below valid (header checksum passed)
//  pkt_type      out  8   header byte 1
//  pkt_id        out  16  header bytes 8..9
//  data_len      out  24  header bytes 4..6, payload length in bytes
//  dout          out  16  payload word
//  dout_valid    out  1   dout valid
//  dout_last     out  1   marks final payload word
//  rd_en         in   1   consumer accepts dout when dout_valid&rd_en
//  pkt_done      out  1   one-cycle pulse: packet complete, data checksum passed
//  err           out  3   sticky: [0] ERR_VERSION [1] ERR_LEN [2] ERR_CHECKSUM; cleared only by rst_n
// BEHAVIOUR
//  - Reset: all outputs 0 except full=1 is NOT used; full=0, state=HDR, counters/sums 0, err=0.
//  - Packet layout (bytes): hdr[10] = {ver, type, rsvd[2], len[3], rsvd, id[2]}; hdr_cksum[4];
//    data[len] padded with 0 to even; data_cksum[4]. Checksum words absent if DISABLE_CHECKSUM.
//  - Checksum = ~(sum mod 2^32 of little-endian 32-bit words), final partial word zero-padded
//    (header: bytes 8..9 form low half of 3rd word). Accumulate one 16-bit half per accepted word.
//  - FSM: HDR(5 words) -> HCK(2) -> DATA(ceil(len/2)) -> DCK(2) -> HDR. len=0 skips DATA.
//    HDR->HCK transition latches fields; version mismatch or len>MAX_DATA_LEN -> set err, go ERROR.
//    End of HCK: mismatch -> ERR_CHECKSUM, ERROR; else hdr_valid pulse next cycle.
//    End of DCK: match -> pkt_done pulse; mismatch -> ERR_CHECKSUM, ERROR.
//  - ERROR: terminal; full=0, input words discarded, no further outputs until rst_n.
//  - Word accepted iff wr_en & ~full. In DATA, word enters 2-entry skid buffer; full=1 when
//    buffer holds 2 entries. Outside DATA full=0 unless buffer non-empty and next packet's DATA
//    would start (hold in HCK end until buffer drained).
//  - dout latency: accepted payload word visible on dout the cycle after acceptance.
//  - Simultaneous accept and drain in the same cycle keeps occupancy; no loss, no duplicate.
//  - Word counter 23 bits; last data word when counter == ceil(len/2)-1; no wrap within MAX_DATA_LEN.
//  - Odd len: last dout high byte forced 0 regardless of din.
//  - rst_n mid-packet: immediate return to HDR, skid buffer emptied, partial packet dropped.
// STRUCTURE
//  - Package pkt_comm_pkg: PKT_HDR_BYTES=10, CKSUM_BYTES=4, err bit indices, FSM state encoding.
//  - Sub-module pkt_comm_cksum32: 16-bit half-word accumulator, clear/add/result(~sum).
//  - Skid buffer inline (2 regs + count).
// TESTING
//  1 Packet ver=2,type=1,len=4,id=0x0007, data 0x40,0x1d,0x63,0xc9, good cksums -> hdr_valid with
//    pkt_type=1,pkt_id=7,data_len=4; dout 0x1d40 then 0x c963 (dout_last); pkt_done; err=0.
//  2 Same packet, rd_en held 0 for 10 cycles -> full=1 after 2 data words, nothing lost when released.
//  3 Odd len=3 (bytes 0xaa,0xbb,0xcc, pad byte 0x55) -> second dout=0x00cc, dout_last=1.
//  4 Header byte0=3 -> err=3'b001, no hdr_valid, subsequent valid packet ignored until rst_n.
//  5 Corrupt data cksum by 1 -> err=3'b100, no pkt_done; DISABLE_CHECKSUM=1 same packet sans
//    cksum words -> pkt_done, err=0.
//  6 rst_n low during DATA word 1 of len=8 packet, then fresh len=0 packet -> hdr_valid, pkt_done, no dout.

Source files
------------

// File: rtl/pkt_comm_pkg.sv
// Shared constants, FSM encoding and helpers for the pkt_comm v2 output decoder.
// Imported by the checksum accumulator and the decoder top.
package pkt_comm_pkg;

  localparam int PKT_HDR_BYTES = 10;
  localparam int CKSUM_BYTES   = 4;
  localparam int HDR_WORDS     = PKT_HDR_BYTES / 2;
  localparam int CK_WORDS      = CKSUM_BYTES / 2;

  localparam int ERR_VERSION  = 0;
  localparam int ERR_LEN      = 1;
  localparam int ERR_CHECKSUM = 2;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_HCK   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DCK   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Number of 16-bit payload words carrying len bytes (odd length rounds up).
  function automatic logic [23:0] words_for_len(input logic [23:0] len);
    return {1'b0, len[23:1]} + {23'd0, len[0]};
  endfunction

endpackage

// File: rtl/pkt_comm_cksum32.sv
// 32-bit one's-complement-style packet checksum built from 16-bit halves.
// hi selects whether the half lands in bits 31:16 or 15:0 of the current 32-bit word.
module pkt_comm_cksum32
  import pkt_comm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        add,
  input  logic        hi,
  input  logic [15:0] half,
  output logic [31:0] result
);

  logic [31:0] sum_r;
  logic [31:0] addend_s;

  assign addend_s = hi ? {half, 16'h0000} : {16'h0000, half};
  assign result   = ~sum_r;

  // Running sum; clear wins over add so a new region always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= 32'd0;
    end else if (clear) begin
      sum_r <= 32'd0;
    end else if (add) begin
      sum_r <= sum_r + addend_s;
    end
  end

endmodule

// File: rtl/pkt_comm_output_decoder.sv
// Parses the 16-bit application output stream into pkt_comm v2 packets, checks both
// checksums and hands header fields and payload words to a valid/ready consumer.
module pkt_comm_output_decoder
  import pkt_comm_pkg::*;
#(
  parameter int DISABLE_CHECKSUM = 0,
  parameter int VERSION          = 2,
  parameter int MAX_DATA_LEN     = 65536
) (
  input  logic        PKT_COMM_CLK,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        wr_en,
  output logic        full,
  output logic        hdr_valid,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic [23:0] data_len,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        dout_last,
  input  logic        rd_en,
  output logic        pkt_done,
  output logic [2:0]  err
);

  state_t      state_r;
  logic [22:0] word_cnt_r;
  logic [7:0]  ver_r;
  logic [7:0]  type_r;
  logic [15:0] len_lo_r;
  logic [7:0]  len_hi_r;
  logic [15:0] ck_lo_r;
  logic        hdr_valid_r;
  logic        pkt_done_r;
  logic [7:0]  pkt_type_r;
  logic [15:0] pkt_id_r;
  logic [23:0] data_len_r;
  logic [2:0]  err_r;

  // Skid buffer entries are {last, word}; entry 0 is the head presented on dout.
  logic [16:0] buf0_r;
  logic [16:0] buf1_r;
  logic [1:0]  buf_cnt_r;

  logic        acc_s;
  logic        last_s;
  logic        full_s;
  logic        data_last_s;
  logic [15:0] pay_s;
  logic [23:0] hdr_len_s;
  logic        ver_bad_s;
  logic        len_bad_s;
  logic        hdr_bad_s;
  logic        ck_match_s;
  logic        err_enter_s;
  logic        push_s;
  logic        pop_s;
  logic        ck_clear_s;
  logic        ck_add_s;
  logic [31:0] ck_result_s;

  assign acc_s       = wr_en & ~full_s;
  assign hdr_len_s   = {len_hi_r, len_lo_r};
  assign ver_bad_s   = (ver_r != 8'(VERSION));
  assign len_bad_s   = ({8'd0, hdr_len_s} > 32'(MAX_DATA_LEN));
  assign hdr_bad_s   = ver_bad_s | len_bad_s;
  assign data_last_s = ({1'b0, word_cnt_r} == (words_for_len(data_len_r) - 24'd1));
  // The pad byte of an odd-length payload never reaches the consumer or the checksum.
  assign pay_s       = (data_last_s && data_len_r[0]) ? {8'h00, din[7:0]} : din;
  assign ck_match_s  = ({din, ck_lo_r} == ck_result_s);
  assign push_s      = acc_s & (state_r == ST_DATA);
  assign pop_s       = (buf_cnt_r != 2'd0) & rd_en;
  assign ck_add_s    = acc_s & ((state_r == ST_HDR) | (state_r == ST_DATA));
  assign ck_clear_s  = acc_s & last_s & ((state_r == ST_HCK) | (state_r == ST_DCK));
  assign err_enter_s = acc_s & last_s &
                       (((state_r == ST_HDR) & hdr_bad_s) |
                        (((state_r == ST_HCK) | (state_r == ST_DCK)) & ~ck_match_s));

  // Per-state last-word decode and back-pressure, all from registered state only.
  always_comb begin
    last_s = 1'b0;
    full_s = 1'b0;
    case (state_r)
      ST_HDR: begin
        last_s = (word_cnt_r == 23'(HDR_WORDS - 1));
        full_s = (DISABLE_CHECKSUM != 0) && last_s && (buf_cnt_r != 2'd0);
      end
      ST_HCK: begin
        last_s = (word_cnt_r == 23'(CK_WORDS - 1));
        full_s = last_s && (buf_cnt_r != 2'd0) && (data_len_r != 24'd0);
      end
      ST_DATA: begin
        last_s = data_last_s;
        full_s = (buf_cnt_r == 2'd2);
      end
      ST_DCK: begin
        last_s = (word_cnt_r == 23'(CK_WORDS - 1));
        full_s = 1'b0;
      end
      default: begin
        last_s = 1'b0;
        full_s = 1'b0;
      end
    endcase
  end

  pkt_comm_cksum32 u_cksum (
    .clk    (PKT_COMM_CLK),
    .rst_n  (rst_n),
    .clear  (ck_clear_s),
    .add    (ck_add_s),
    .hi     (word_cnt_r[0]),
    .half   ((state_r == ST_DATA) ? pay_s : din),
    .result (ck_result_s)
  );

  // Packet framing FSM with header capture, checksum compare and status pulses.
  always_ff @(posedge PKT_COMM_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HDR;
      word_cnt_r  <= 23'd0;
      ver_r       <= 8'd0;
      type_r      <= 8'd0;
      len_lo_r    <= 16'd0;
      len_hi_r    <= 8'd0;
      ck_lo_r     <= 16'd0;
      hdr_valid_r <= 1'b0;
      pkt_done_r  <= 1'b0;
      pkt_type_r  <= 8'd0;
      pkt_id_r    <= 16'd0;
      data_len_r  <= 24'd0;
      err_r       <= 3'd0;
    end else begin
      hdr_valid_r <= 1'b0;
      pkt_done_r  <= 1'b0;
      case (state_r)
        ST_HDR: begin
          if (acc_s) begin
            if (word_cnt_r == 23'd0) begin
              ver_r  <= din[7:0];
              type_r <= din[15:8];
            end
            if (word_cnt_r == 23'd2) len_lo_r <= din;
            if (word_cnt_r == 23'd3) len_hi_r <= din[7:0];
            if (last_s) begin
              word_cnt_r <= 23'd0;
              if (hdr_bad_s) begin
                err_r[ERR_VERSION] <= err_r[ERR_VERSION] | ver_bad_s;
                err_r[ERR_LEN]     <= err_r[ERR_LEN] | len_bad_s;
                state_r            <= ST_ERROR;
              end else begin
                pkt_type_r <= type_r;
                pkt_id_r   <= din;
                data_len_r <= hdr_len_s;
                if (DISABLE_CHECKSUM != 0) begin
                  hdr_valid_r <= 1'b1;
                  if (hdr_len_s == 24'd0) begin
                    pkt_done_r <= 1'b1;
                    state_r    <= ST_HDR;
                  end else begin
                    state_r <= ST_DATA;
                  end
                end else begin
                  state_r <= ST_HCK;
                end
              end
            end else begin
              word_cnt_r <= word_cnt_r + 23'd1;
            end
          end
        end
        ST_HCK: begin
          if (acc_s) begin
            if (!last_s) begin
              ck_lo_r    <= din;
              word_cnt_r <= word_cnt_r + 23'd1;
            end else begin
              word_cnt_r <= 23'd0;
              if (ck_match_s) begin
                hdr_valid_r <= 1'b1;
                state_r     <= (data_len_r == 24'd0) ? ST_DCK : ST_DATA;
              end else begin
                err_r[ERR_CHECKSUM] <= 1'b1;
                state_r             <= ST_ERROR;
              end
            end
          end
        end
        ST_DATA: begin
          if (acc_s) begin
            if (last_s) begin
              word_cnt_r <= 23'd0;
              if (DISABLE_CHECKSUM != 0) begin
                pkt_done_r <= 1'b1;
                state_r    <= ST_HDR;
              end else begin
                state_r <= ST_DCK;
              end
            end else begin
              word_cnt_r <= word_cnt_r + 23'd1;
            end
          end
        end
        ST_DCK: begin
          if (acc_s) begin
            if (!last_s) begin
              ck_lo_r    <= din;
              word_cnt_r <= word_cnt_r + 23'd1;
            end else begin
              word_cnt_r <= 23'd0;
              if (ck_match_s) begin
                pkt_done_r <= 1'b1;
                state_r    <= ST_HDR;
              end else begin
                err_r[ERR_CHECKSUM] <= 1'b1;
                state_r             <= ST_ERROR;
              end
            end
          end
        end
        ST_ERROR: begin
          state_r <= ST_ERROR;
        end
        default: begin
          state_r <= ST_HDR;
        end
      endcase
    end
  end

  // Two-entry payload skid buffer; emptied when the decoder falls into ERROR.
  always_ff @(posedge PKT_COMM_CLK or negedge rst_n) begin
    if (!rst_n) begin
      buf0_r    <= 17'd0;
      buf1_r    <= 17'd0;
      buf_cnt_r <= 2'd0;
    end else if (err_enter_s) begin
      buf_cnt_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (buf_cnt_r == 2'd0) buf0_r <= {data_last_s, pay_s};
          else buf1_r <= {data_last_s, pay_s};
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b01: begin
          buf0_r    <= buf1_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_r == 2'd1) begin
            buf0_r <= {data_last_s, pay_s};
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= {data_last_s, pay_s};
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

  assign full       = full_s;
  assign hdr_valid  = hdr_valid_r;
  assign pkt_type   = pkt_type_r;
  assign pkt_id     = pkt_id_r;
  assign data_len   = data_len_r;
  assign dout       = buf0_r[15:0];
  assign dout_valid = (buf_cnt_r != 2'd0);
  assign dout_last  = buf0_r[16] & (buf_cnt_r != 2'd0);
  assign pkt_done   = pkt_done_r;
  assign err        = err_r;

endmodule
